// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
//   Time-multiplexed FIR controller. Keeps a TAPS-deep sample delay line,
//   walks the coefficient RAM one tap per cycle, feeds an external shared
//   Q32.32 multiplier and accumulates the products with per-step saturation.
//   One filtered output is produced per accepted sample, every TAPS+4 cycles.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   sample handshake (ready only in IDLE)
//   in_sample           signed Q32.32 sample
//   coef_addr/coef_data coefficient RAM, 1-cycle read latency
//   mul_a/mul_b/mul_p   shared multiplier (coef, delayed sample, product)
//   out_valid/out_data  one-cycle result pulse, data held until next result
//   busy                high outside IDLE
module fir_mac_sequencer #(
  parameter int TAPS = 16,
  parameter int AW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_sample,
  output logic [AW-1:0] coef_addr,
  input  logic [63:0]   coef_data,
  output logic [63:0]   mul_a,
  output logic [63:0]   mul_b,
  input  logic [63:0]   mul_p,
  output logic          out_valid,
  output logic [63:0]   out_data,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, DONE} state_t;

  state_t                 state, state_nx;
  logic [TAPS-1:0][63:0]  x;         // x[0] newest
  logic [AW-1:0]          cnt;       // tap address being issued
  logic [AW-1:0]          opk;       // tap whose coefficient is on coef_data now
  logic                   dcnt;      // second DRAIN cycle
  logic [1:0]             vld_pipe;  // [0] operand stage, [1] accumulate stage
  logic [63:0]            prod;
  logic [63:0]            acc;
  logic [63:0]            acc_sum;
  logic                   accept;
  logic                   last_issue;

  // 65-bit sum, clamp when the two top bits disagree.
  function automatic logic [63:0] sat64(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = {a[63], a} + {b[63], b};
    if (s[64] != s[63])
      return s[64] ? {1'b1, 63'b0} : {1'b0, {63{1'b1}}};
    return s[63:0];
  endfunction

  assign accept     = in_valid && in_ready;
  assign last_issue = (cnt == AW'(TAPS - 1));
  assign acc_sum    = sat64(acc, prod);

  // Operands only driven while an operand stage is live so the shared
  // multiplier sees zeros otherwise.
  assign mul_a = vld_pipe[0] ? coef_data : 64'd0;
  assign mul_b = vld_pipe[0] ? x[opk]    : 64'd0;

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    coef_addr = cnt;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        in_ready  = !rst;
        coef_addr = '0;
        if (in_valid && !rst) state_nx = MAC;
      end
      MAC:   if (last_issue) state_nx = DRAIN;
      DRAIN: if (dcnt)       state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      x        <= '0;
      cnt      <= '0;
      opk      <= '0;
      dcnt     <= 1'b0;
      vld_pipe <= '0;
      prod     <= '0;
      acc      <= '0;
      out_data <= '0;
    end else begin
      state    <= state_nx;
      vld_pipe <= {vld_pipe[0], state == MAC};
      opk      <= cnt;
      dcnt     <= (state == DRAIN) ? ~dcnt : 1'b0;

      if (vld_pipe[0]) prod <= mul_p;
      if (vld_pipe[1]) acc  <= acc_sum;

      // Last accumulate step lands in the second DRAIN cycle.
      if (state == DRAIN && dcnt) out_data <= acc_sum;

      if (accept) begin
        x   <= {x[TAPS-2:0], in_sample};
        acc <= '0;
        cnt <= '0;
      end else if (state == MAC && !last_issue) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
module tb_fir_mac_sequencer;
  localparam int TAPS = 16;
  localparam int AW   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_sample;
  logic [AW-1:0] coef_addr;
  logic [63:0]   coef_data;
  logic [63:0]   mul_a, mul_b, mul_p;
  logic          out_valid;
  logic [63:0]   out_data;
  logic          busy;

  fir_mac_sequencer #(.TAPS(TAPS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .coef_addr(coef_addr), .coef_data(coef_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .out_valid(out_valid),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // coefficient RAM and multiplier models
  logic [63:0] h [TAPS];
  always @(posedge clk) coef_data <= h[coef_addr];

  function automatic logic [63:0] qmul(input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] p;
    p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
    return p[95:32];
  endfunction

  assign mul_p = qmul(mul_a, mul_b);

  function automatic logic [63:0] qsat(input logic [63:0] a, input logic [63:0] b);
    logic signed [64:0] s;
    s = $signed({a[63], a}) + $signed({b[63], b});
    if (s > 65'sh0_7FFF_FFFF_FFFF_FFFF) return 64'h7FFF_FFFF_FFFF_FFFF;
    if (s < -65'sh0_8000_0000_0000_0000) return 64'h8000_0000_0000_0000;
    return s[63:0];
  endfunction

  int npass = 0, ntot = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // scoreboard / monitor
  logic [63:0] xm [TAPS];
  logic [63:0] exp_q [$];
  logic [63:0] got_q [$];
  int cyc = 0, ph = 0, last_acc = 0, acc_cnt = 0;
  bit active = 0, have_prev = 0, bp_mode = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      active = 0;
      have_prev = 0;
      for (int k = 0; k < TAPS; k++) xm[k] = '0;
      exp_q.delete();
    end else begin
      if (active) begin
        ph++;
        if (ph > TAPS + 3) active = 0;
      end
      if (active) begin
        if (ph >= 1 && ph <= TAPS) chk("coef_addr", 64'(coef_addr), 64'(ph - 1));
        if (ph >= 2 && ph <= TAPS + 1) begin
          chk("mul_a", mul_a, h[ph-2]);
          chk("mul_b", mul_b, xm[ph-2]);
        end
        chk("busy_run", 64'(busy), 64'd1);
        chk("ready_run", 64'(in_ready), 64'd0);
        if (ph == TAPS + 3) chk("out_valid", 64'(out_valid), 64'd1);
      end else begin
        chk("busy_idle", 64'(busy), 64'd0);
        chk("ready_idle", 64'(in_ready), 64'd1);
        chk("mul_a_idle", mul_a, 64'd0);
        chk("mul_b_idle", mul_b, 64'd0);
      end
      if (out_valid) begin
        if (!(active && ph == TAPS + 3)) chk("ov_spurious", 64'd1, 64'd0);
        got_q.push_back(out_data);
        if (exp_q.size() > 0) chk("out_data", out_data, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        if (bp_mode && have_prev) chk("bp_gap", 64'(cyc - last_acc), 64'(TAPS + 4));
        have_prev = 1;
        last_acc = cyc;
        acc_cnt++;
        for (int k = TAPS - 1; k > 0; k--) xm[k] = xm[k-1];
        xm[0] = in_sample;
        begin
          logic [63:0] y;
          y = '0;
          for (int k = 0; k < TAPS; k++) y = qsat(y, qmul(h[k], xm[k]));
          exp_q.push_back(y);
        end
        ph = 0;
        active = 1;
      end
    end
  end

  task automatic send(input logic [63:0] s);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_sample = s;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++n > 100) begin chk("send_timeout", 64'd0, 64'd1); break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || active) && n < 200) begin @(posedge clk); n++; end
    if (n >= 200) chk("drain_timeout", 64'd0, 64'd1);
    repeat (3) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    got_q.delete();
  endtask

  task automatic run_bp(input logic [63:0] s, input int n);
    int t;
    t = 0;
    bp_mode = 1;
    have_prev = 0;
    acc_cnt = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_sample = s;
    while (acc_cnt < n && t < 40 * n) begin @(posedge clk); t++; end
    if (t >= 40 * n) chk("bp_timeout", 64'd0, 64'd1);
    #1 in_valid = 1'b0;
    bp_mode = 0;
    drain();
  endtask

  task automatic got_chk(input string tag, input int i, input logic [63:0] exp);
    if (got_q.size() > i) chk(tag, got_q[i], exp);
    else chk({tag, "_missing"}, 64'(got_q.size()), 64'(i + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_sample = '0;
    for (int k = 0; k < TAPS; k++) h[k] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", 64'(in_ready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_coef_addr", 64'(coef_addr), 64'd0);

    // impulse through h[k] = k+1
    for (int k = 0; k < TAPS; k++) h[k] = 64'(k + 1) << 32;
    send(64'h0000_0001_0000_0000);
    for (int i = 1; i < TAPS; i++) send(64'd0);
    drain();
    chk("imp_count", 64'(got_q.size()), 64'(TAPS));
    for (int i = 0; i < TAPS; i++) got_chk("impulse", i, 64'(i + 1) << 32);

    // DC ramp
    do_reset();
    for (int k = 0; k < TAPS; k++) h[k] = 64'h0000_0000_1000_0000;
    for (int i = 0; i < 20; i++) send(64'h0000_0001_0000_0000);
    drain();
    for (int n = 1; n <= 20; n++)
      got_chk("dc_ramp", n - 1, (n <= 16) ? 64'(n) * 64'h1000_0000 : 64'h0000_0001_0000_0000);

    // positive saturation with back-pressure (in_valid held high)
    do_reset();
    for (int k = 0; k < TAPS; k++) h[k] = 64'h0000_0002_0000_0000;
    run_bp(64'h2000_0000_0000_0000, 3);
    chk("bp_outputs", 64'(got_q.size()), 64'd3);
    got_chk("sat_pos1", 0, 64'h4000_0000_0000_0000);
    got_chk("sat_pos2", 1, 64'h7FFF_FFFF_FFFF_FFFF);
    got_chk("sat_pos3", 2, 64'h7FFF_FFFF_FFFF_FFFF);

    // negative saturation
    do_reset();
    run_bp(64'hE000_0000_0000_0000, 3);
    got_chk("sat_neg1", 0, 64'hC000_0000_0000_0000);
    got_chk("sat_neg2", 1, 64'h8000_0000_0000_0000);
    got_chk("sat_neg3", 2, 64'h8000_0000_0000_0000);

    // reset in the middle of a computation
    do_reset();
    for (int k = 0; k < TAPS; k++) h[k] = 64'(k + 1) << 32;
    send(64'h0000_0001_0000_0000);
    drain();
    got_q.delete();
    send(64'h0000_0003_0000_0000);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    repeat (30) @(posedge clk);
    chk("post_rst_noout", 64'(got_q.size()), 64'd0);
    send(64'h0000_0001_0000_0000);
    drain();
    got_chk("post_rst_imp", 0, 64'h0000_0001_0000_0000);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
